// File: rtl/calc_ctl_pkg.sv
// Shared encodings for the calculator sequencer: funct codes, FSM states,
// and the default multiplier watchdog limit.
package calc_ctl_pkg;

  localparam logic [2:0] FN_ADD    = 3'b000;
  localparam logic [2:0] FN_SUB    = 3'b001;
  localparam logic [2:0] FN_ADDACC = 3'b010;
  localparam logic [2:0] FN_SUBACC = 3'b011;
  localparam logic [2:0] FN_MUL    = 3'b100;
  localparam logic [2:0] FN_CLR    = 3'b101;
  localparam logic [2:0] FN_NOP    = 3'b110;
  localparam logic [2:0] FN_HALT   = 3'b111;

  localparam int unsigned DEFAULT_MUL_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_MUL_START = 3'd2,
    ST_MUL_WAIT  = 3'd3,
    ST_MUL_WB    = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Codes 000..011 drive the adder/subtractor path.
  function automatic logic is_addsub(input logic [2:0] f);
    return (f[2] == 1'b0);
  endfunction

endpackage

// File: rtl/calc_sequencer_mul_watchdog.sv
// Multiplier handshake watchdog: counts cycles spent waiting for mul_done
// and flags the last allowed cycle.
module mul_watchdog
  import calc_ctl_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = DEFAULT_MUL_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(MUL_TIMEOUT - 1);

  logic [15:0] count;

  // Cycle counter; holds at the terminal value so expired stays asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Sequencing controller for the calculator datapath: accepts one decoded
// instruction at a time, drives the datapath selects and write strobes, and
// handshakes with the multi-cycle multiplier under a watchdog.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | ready for the next instruction
//   EXEC         | single-cycle add/sub/clr/nop; write back and advance PC
//   MUL_START    | pulse mul_start
//   MUL_WAIT     | wait for mul_done; abort with mul_err on timeout
//   MUL_WB       | write multiplier result and advance PC
//   HALT         | absorbing until reset; PC advances once on entry
module calc_sequencer
  import calc_ctl_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = DEFAULT_MUL_TIMEOUT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [2:0]       funct,
  output logic             instr_ready,
  output logic             sign_ctl,
  output logic             store_prev_ctl,
  output logic             op_sel,
  output logic             accum_we,
  output logic             accum_clr,
  output logic             pc_we,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             busy,
  output logic             halted,
  output logic             mul_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e     state;
  state_e     state_nxt;
  logic [2:0] f_q;
  logic       halt_q;
  logic       wd_expired;
  logic       accept;
  logic       timeout_abort;

  assign accept        = instr_valid && (state == ST_IDLE);
  // done wins over a same-cycle timeout
  assign timeout_abort = (state == ST_MUL_WAIT) && wd_expired && !mul_done;

  mul_watchdog #(
    .MUL_TIMEOUT (MUL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != ST_MUL_WAIT),
    .en      (state == ST_MUL_WAIT),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the function code only on the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q <= '0;
    end else if (accept) begin
      f_q <= funct;
    end
  end

  // Sticky error, HALT-entry tracking and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_err <= 1'b0;
      halt_q  <= 1'b0;
      retired <= '0;
    end else begin
      if (timeout_abort) begin
        mul_err <= 1'b1;
      end
      halt_q <= (state == ST_HALT);
      if (pc_we) begin
        retired <= retired + CNT_ONE;
      end
    end
  end

  // Next-state and output decode from state and f_q.
  always_comb begin
    state_nxt      = state;
    instr_ready    = 1'b0;
    sign_ctl       = 1'b0;
    store_prev_ctl = 1'b0;
    op_sel         = 1'b0;
    accum_we       = 1'b0;
    accum_clr      = 1'b0;
    pc_we          = 1'b0;
    mul_start      = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (funct == FN_MUL) begin
            state_nxt = ST_MUL_START;
          end else if (funct == FN_HALT) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        busy  = 1'b1;
        pc_we = 1'b1;
        if (is_addsub(f_q)) begin
          sign_ctl       = f_q[0];
          store_prev_ctl = ~f_q[1];
          accum_we       = 1'b1;
        end
        if (f_q == FN_CLR) begin
          accum_we  = 1'b1;
          accum_clr = 1'b1;
        end
        state_nxt = ST_IDLE;
      end
      ST_MUL_START: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        op_sel    = 1'b1;
        state_nxt = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        busy   = 1'b1;
        op_sel = 1'b1;
        if (mul_done) begin
          state_nxt = ST_MUL_WB;
        end else if (wd_expired) begin
          pc_we     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL_WB: begin
        busy      = 1'b1;
        op_sel    = 1'b1;
        accum_we  = 1'b1;
        pc_we     = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
        pc_we  = ~halt_q;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
